// File: rtl/hsbuffer_if.sv
// hsbuffer_if: upstream and downstream four-phase handshake bundle with fill status
interface hsbuffer_if #(
    parameter int WIDTH = 8,
    parameter int ADDRW = 2
);
    logic [WIDTH-1:0] a;
    logic             req_in;
    logic             ack_out;
    logic [WIDTH-1:0] q;
    logic             req_out;
    logic             ack_in;
    logic [ADDRW:0]   count;
    logic             full;
    logic             empty;

    modport slave (
        input  a, req_in, ack_in,
        output ack_out, q, req_out, count, full, empty
    );

    modport master (
        output a, req_in, ack_in,
        input  ack_out, q, req_out, count, full, empty
    );
endinterface

// File: rtl/hsbuffer.sv
// hsbuffer: elastic FIFO stage, four-phase consumer upstream and four-phase producer downstream
module hsbuffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int ADDRW = 2
) (
    input logic       clk,
    input logic       reset,
    hsbuffer_if.slave bus
);
    localparam logic [ADDRW:0] FULL_CNT = (ADDRW+1)'(DEPTH);

    typedef enum logic {U_IDLE = 1'b0, U_ACK = 1'b1} u_state_t;
    typedef enum logic [1:0] {D_IDLE = 2'b00, D_REQ = 2'b01, D_WAIT = 2'b10} d_state_t;

    u_state_t         u_state_q, u_state_d;
    d_state_t         d_state_q, d_state_d;
    logic [ADDRW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ADDRW:0]   count_q, count_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push, pop;

    // State and datapath registers; memory contents are deliberately left out of reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            u_state_q <= U_IDLE;
            d_state_q <= D_IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            q_q       <= '0;
        end else begin
            u_state_q <= u_state_d;
            d_state_q <= d_state_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            q_q       <= q_d;
        end
    end

    // Storage array, written only on an accepted upstream word
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr_q] <= bus.a;
    end

    // Upstream next state: a persisting req in U_ACK simply holds the acknowledge
    always_comb begin
        u_state_d = (u_state_q == U_IDLE) ? (push ? U_ACK : U_IDLE)
                                          : (bus.req_in ? U_ACK : U_IDLE);
    end

    // Downstream next state: an early ack in D_IDLE is ignored
    always_comb begin
        d_state_d = d_state_q;
        case (d_state_q)
            D_IDLE:  if (!empty_q) d_state_d = D_REQ;
            D_REQ:   if (bus.ack_in) d_state_d = D_WAIT;
            D_WAIT:  if (!bus.ack_in) d_state_d = D_IDLE;
            default: d_state_d = D_IDLE;
        endcase
    end

    // Push/pop decisions use the pre-edge full/empty so a same-edge pop never admits a push when full
    always_comb begin
        push    = (u_state_q == U_IDLE) && bus.req_in && !full_q;
        pop     = (d_state_q == D_IDLE) && !empty_q;
        wptr_d  = wptr_q + ADDRW'(push);
        rptr_d  = rptr_q + ADDRW'(pop);
        count_d = count_q + (ADDRW+1)'(push) - (ADDRW+1)'(pop);
        full_d  = count_d == FULL_CNT;
        empty_d = count_d == '0;
        q_d     = pop ? mem[rptr_q] : q_q;
    end

    assign bus.ack_out = u_state_q == U_ACK;
    assign bus.req_out = d_state_q[0];
    assign bus.q       = q_q;
    assign bus.count   = count_q;
    assign bus.full    = full_q;
    assign bus.empty   = empty_q;
endmodule

// File: tb/tb_hsbuffer.sv
// tb_hsbuffer: randomized handshake bench with a cycle model and an in-order data scoreboard
`timescale 1ns/1ps
module tb_hsbuffer;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int ADDRW = 2;
    localparam int TMO   = 300;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    hsbuffer_if #(.WIDTH(WIDTH), .ADDRW(ADDRW)) bif ();

    hsbuffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDRW(ADDRW)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bif.slave)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] exp_q [$];
    bit               chk_en = 1'b0;
    bit               ack_m, req_m, wait_m, push_m, pop_m, p_req;
    int               cnt_m;
    logic [WIDTH-1:0] p_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Cycle model of the handshake rules plus the data scoreboard consumer
    always @(posedge clk) begin
        #1;
        if (!chk_en) begin
            ack_m = 0; req_m = 0; wait_m = 0; cnt_m = 0; p_req = 0; p_q = '0;
        end else begin
            push_m = !ack_m && bif.req_in && cnt_m < DEPTH;
            pop_m  = !req_m && !wait_m && cnt_m > 0;
            wait_m = bif.ack_in && (req_m || wait_m);
            ack_m  = ack_m ? bif.req_in : push_m;
            req_m  = req_m ? !bif.ack_in : pop_m;
            cnt_m  = cnt_m + int'(push_m) - int'(pop_m);
            check("ack_out", bif.ack_out, ack_m);
            check("req_out", bif.req_out, req_m);
            check("count", bif.count, cnt_m);
            check("full", bif.full, cnt_m == DEPTH);
            check("empty", bif.empty, cnt_m == 0);
            if (bif.req_out && !p_req) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL q_data: got %0h, expected no word at %0t", bif.q, $time);
                end else
                    check("q_data", bif.q, exp_q.pop_front());
            end
            if (bif.req_out && p_req)
                check("q_stable", bif.q, p_q);
            p_req = bif.req_out;
            p_q   = bif.q;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack_out"}, bif.ack_out, 0);
        check({tag, "_req_out"}, bif.req_out, 0);
        check({tag, "_q"}, bif.q, 0);
        check({tag, "_count"}, bif.count, 0);
        check({tag, "_full"}, bif.full, 0);
        check({tag, "_empty"}, bif.empty, 1);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        chk_en = 0;
        #3 rst_n = 0;
        #1 check_reset_outputs({tag, "_async"});
        repeat (3) begin
            @(negedge clk);
            bif.req_in = 1'($urandom);
            bif.ack_in = 1'($urandom);
            bif.a      = WIDTH'($urandom);
        end
        @(negedge clk);
        check_reset_outputs({tag, "_held"});
        bif.req_in = 0;
        bif.ack_in = 0;
        rst_n      = 1;
        exp_q.delete();
        chk_en     = 1;
    endtask

    task automatic write_word(input logic [WIDTH-1:0] d);
        int t;
        @(negedge clk);
        bif.a      = d;
        bif.req_in = 1;
        t = 0;
        while (!bif.ack_out && t < TMO) begin @(negedge clk); t++; end
        if (!bif.ack_out) begin
            fail("write_ack_rise");
            bif.req_in = 0;
            return;
        end
        exp_q.push_back(d);
        bif.req_in = 0;
        @(negedge clk);
        t = 0;
        while (bif.ack_out && t < TMO) begin @(negedge clk); t++; end
        if (bif.ack_out) fail("write_ack_fall");
    endtask

    task automatic read_word(input int dly);
        int t;
        @(negedge clk);
        t = 0;
        while (!bif.req_out && t < TMO) begin @(negedge clk); t++; end
        if (!bif.req_out) begin
            fail("read_req_rise");
            return;
        end
        repeat (dly) @(negedge clk);
        bif.ack_in = 1;
        @(negedge clk);
        t = 0;
        while (bif.req_out && t < TMO) begin @(negedge clk); t++; end
        if (bif.req_out) fail("read_req_fall");
        bif.ack_in = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] d;
        bif.a = '0; bif.req_in = 0; bif.ack_in = 0;
        do_reset("rst");

        // single word: ack one edge after req, word on q two edges after push
        @(negedge clk);
        bif.a = 8'hA5; bif.req_in = 1;
        @(negedge clk);
        check("single_ack", bif.ack_out, 1);
        check("single_cnt1", bif.count, 1);
        exp_q.push_back(8'hA5);
        bif.req_in = 0;
        @(negedge clk);
        check("single_req", bif.req_out, 1);
        check("single_q", bif.q, 8'hA5);
        check("single_cnt0", bif.count, 0);
        check("single_ack_low", bif.ack_out, 0);
        bif.ack_in = 1;
        @(negedge clk);
        check("single_req_low", bif.req_out, 0);
        bif.ack_in = 0;
        repeat (2) @(negedge clk);

        // fill and stall: one word sits on q, four in the FIFO
        for (int i = 1; i <= 5; i++) write_word(WIDTH'(i));
        @(negedge clk);
        check("fill_count", bif.count, DEPTH);
        check("fill_full", bif.full, 1);
        fork
            write_word(8'h06);
            begin
                repeat (6) @(negedge clk);
                check("stall_ack", bif.ack_out, 0);
                check("stall_full", bif.full, 1);
                for (int i = 0; i < 6; i++) read_word($urandom_range(0, 3));
            end
        join
        repeat (3) @(negedge clk);

        // same-edge push and pop with count 2, repeated across pointer wrap
        for (int i = 0; i < 3; i++) write_word(WIDTH'(8'h10 + i));
        @(negedge clk);
        check("sim_pre_count", bif.count, 2);
        for (int i = 0; i < 5; i++) begin
            d = WIDTH'($urandom);
            bif.ack_in = 1;
            @(negedge clk);
            bif.ack_in = 0;
            @(negedge clk);
            bif.a = d; bif.req_in = 1;
            @(negedge clk);
            exp_q.push_back(d);
            check("sim_count", bif.count, 2);
            check("sim_ack", bif.ack_out, 1);
            check("sim_req", bif.req_out, 1);
            bif.req_in = 0;
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) read_word($urandom_range(0, 2));
        repeat (3) @(negedge clk);

        // reset mid-operation discards stored and in-flight words
        for (int i = 0; i < 4; i++) write_word(WIDTH'($urandom));
        @(negedge clk);
        check("mid_count", bif.count, 3);
        check("mid_req", bif.req_out, 1);
        do_reset("mid");
        write_word(8'h3C);
        read_word(1);
        @(negedge clk);
        check("post_reset_empty", bif.empty, 1);

        // streaming with random timing on both sides
        d = WIDTH'($urandom);
        fork
            for (int i = 0; i < 150; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                write_word(WIDTH'(d + WIDTH'(i)));
            end
            for (int i = 0; i < 150; i++) begin
                repeat ($urandom_range(0, 4)) @(negedge clk);
                read_word($urandom_range(0, 3));
            end
        join
        repeat (4) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        check("final_count", bif.count, 0);
        check("final_empty", bif.empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
